command_router: RTL
===================

# command_router

Demultiplexes the single arbitrated command stream back to its two requesters. Each accepted word carries a 2-bit source tag: 1 sends it to channel 1, 2 sends it to channel 2. Each channel has its own first-word-fall-through FIFO with a valid/ready handshake toward its consumer. The block sits on the arbiter's output side and applies per-channel back-pressure and branch flush.

## Interface
- `DEPTH`, 4: entries per channel FIFO; must be a power of two, minimum 2.
- `PTR_W`, 2: pointer width, equal to log2(DEPTH).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  32  command word.
- `in_id`  in  2  source tag: 1 means channel 1, 2 means channel 2, 0 or 3 are invalid.
- `in_addr`  in  32  address accompanying the command.
- `in_valid`  in  1  the input word is valid.
- `in_ready`  out  1  the block can accept the input word (combinational).
- `flush_1`, `flush_2`  in  1  discard all contents of the named channel, e.g. on a branch.
- `out_data_1`, `out_data_2`  out  32  head-entry command of each channel.
- `out_addr_1`, `out_addr_2`  out  32  head-entry address of each channel.
- `out_valid_1`, `out_valid_2`  out  1  the channel FIFO is non-empty.
- `out_ready_1`, `out_ready_2`  in  1  the consumer takes the head entry.
- `count_1`, `count_2`  out  PTR_W+1  current occupancy of each channel, 0..DEPTH.
- `bad_id`  out  1  one-cycle pulse when a word with tag 0 or 3 is accepted.

## Operation
- Accept: an input word is accepted when `in_valid && in_ready`.
- `in_ready` by tag and flush state:
  - tag 1: `in_ready = !full_1 || flush_1`.
  - tag 2: `in_ready = !full_2 || flush_2`.
  - tag 0 or 3: `in_ready = 1`.
  - "Full" means count == DEPTH before this cycle. A pop in the same cycle does not free a slot for a push (no pass-through when full).
- Push: an accepted word with tag n, and `flush_n` low, writes {data, addr} at the write pointer of channel n. The write pointer increments modulo DEPTH and the count increments.
- Invalid tag: an accepted word with tag 0 or 3 is dropped. `bad_id` goes high on the next cycle for exactly one cycle. No FIFO state changes.
- Pop: when `out_valid_n && out_ready_n` and `flush_n` is low, the read pointer of channel n increments modulo DEPTH and the count decrements.
- `out_ready_n` while empty is ignored.
- Push and pop in the same cycle on a non-full, non-empty channel: the count is unchanged and both pointers advance.
- Push and pop on an empty channel: the pop is ignored and the push succeeds (count goes 0 to 1).
- Flush: `flush_n` high sets channel n's pointers and count to 0 at the next edge.
  - A same-cycle pop on channel n is void.
  - A same-cycle accepted word tagged n is consumed and discarded; it is wrong-path.
  - The other channel is unaffected.
- Outputs: `out_valid_n = (count_n != 0)`.
  - `out_data_n` and `out_addr_n` show the head entry while valid.
  - Both are forced to 0 while `out_valid_n` is 0.
- Channel order: order within each channel is preserved (FIFO). There is no ordering relation between channels.
- Pointer wrap: pointers wrap at DEPTH. The count distinguishes full from empty.

## Timing
- Reset values, with `reset` high at an edge:
  - all pointers and counts become 0.
  - `out_valid_n` = 0, `out_data_n` = 0, `out_addr_n` = 0, `count_n` = 0, `bad_id` = 0.
  - `in_ready` afterwards follows the rules above (1 for any tag while empty).
- Reset mid-operation discards all entries and has priority over push, pop and flush.
- FIFO storage itself is not reset; it is masked by count = 0.
- Latency: a word accepted at edge k appears on `out_*_n` with `out_valid_n` = 1 in the cycle after edge k. There is one cycle of latency from input to output.
- Throughput: one push and one pop per channel per cycle. A full channel still allows one pop per cycle.
- Back-pressure: a full channel only stalls words tagged for it. `in_ready` is recomputed every cycle from `in_id` and the registered state.

## Test plan
- Basic routing: push tags 1, 2, 1 with data 0xA1, 0xB2, 0xA3, holding both `out_ready` low. Expect channel 1 to show 0xA1 with count 2, channel 2 to show 0xB2 with count 1, and `out_valid_*` to rise one cycle after each accept.
- Full and back-pressure (DEPTH=4): push 5 words tagged 1 with `out_ready_1` = 0.
  - Expect `in_ready` = 0 on the 5th word, `count_1` = 4, and tag-2 words still accepted.
  - Raise `out_ready_1` for one cycle: `count_1` = 3, then the 5th word is accepted.
- Pointer wraparound: with both `out_ready` held at 1, stream 10 words tagged 1 (0x10..0x19). Expect 0x10..0x19 out in order with no loss and `count_1` ≤ 1 throughout.
- Flush collision: channel 1 holds 3 entries.
  - Assert `flush_1` in the same cycle as an accepted tag-1 word 0xFF and `out_ready_1` = 1.
  - Expect `count_1` = 0 and `out_data_1` = 0 next cycle, with 0xFF never appearing.
  - Expect channel 2 contents intact.
- Invalid tag: send `in_id` = 3 with data 0x55. Expect `in_ready` = 1, `bad_id` high for exactly one cycle, and both counts unchanged.
- Reset mid-operation: fill both channels with 2 entries each, then assert `reset` for 1 cycle. Expect all outputs at their reset values next cycle; a new tag-2 word is then visible one cycle after it is accepted.

Source files
------------

// File: rtl/command_router.sv
// rtl/command_router.sv - routes tagged command words into two per-channel FWFT FIFOs
// Each channel supports flush, back-pressure and one push plus one pop per cycle.
module command_router #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_data,
    input  logic [1:0]       in_id,
    input  logic [31:0]      in_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush_1,
    input  logic             flush_2,
    output logic [31:0]      out_data_1,
    output logic [31:0]      out_data_2,
    output logic [31:0]      out_addr_1,
    output logic [31:0]      out_addr_2,
    output logic             out_valid_1,
    output logic             out_valid_2,
    input  logic             out_ready_1,
    input  logic             out_ready_2,
    output logic [PTR_W:0]   count_1,
    output logic [PTR_W:0]   count_2,
    output logic             bad_id
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // Index 0 is channel 1, index 1 is channel 2; each entry is {data, addr}.
    logic [63:0]      mem [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr [2];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [PTR_W:0]   count  [2];
    logic [1:0]       flush;
    logic [1:0]       pop_req;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             accept;
    logic             bad_id_r;

    assign flush   = {flush_2, flush_1};
    assign pop_req = {out_ready_2, out_ready_1};

    always_comb begin
        full = '0;
        for (int ch = 0; ch < 2; ch++) begin
            full[ch] = (count[ch] == FULL_COUNT);
        end
    end

    // Fullness is judged on registered state only, so a same-cycle pop never frees a slot.
    always_comb begin
        in_ready = 1'b1;
        case (in_id)
            2'd1:    in_ready = !full[0] || flush_1;
            2'd2:    in_ready = !full[1] || flush_2;
            default: in_ready = 1'b1;
        endcase
    end

    always_comb begin
        accept = in_valid && in_ready;
        push   = '0;
        pop    = '0;
        for (int ch = 0; ch < 2; ch++) begin
            push[ch] = accept && (in_id == 2'(ch + 1)) && !flush[ch];
            pop[ch]  = (count[ch] != '0) && pop_req[ch] && !flush[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < 2; ch++) begin
                wr_ptr[ch] <= '0;
                rd_ptr[ch] <= '0;
                count[ch]  <= '0;
            end
            bad_id_r <= 1'b0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (flush[ch]) begin
                    wr_ptr[ch] <= '0;
                    rd_ptr[ch] <= '0;
                    count[ch]  <= '0;
                end else begin
                    if (push[ch]) wr_ptr[ch] <= wr_ptr[ch] + PTR_W'(1);
                    if (pop[ch])  rd_ptr[ch] <= rd_ptr[ch] + PTR_W'(1);
                    case ({push[ch], pop[ch]})
                        2'b10:   count[ch] <= count[ch] + (PTR_W + 1)'(1);
                        2'b01:   count[ch] <= count[ch] - (PTR_W + 1)'(1);
                        default: count[ch] <= count[ch];
                    endcase
                end
            end
            bad_id_r <= accept && ((in_id == 2'd0) || (in_id == 2'd3));
        end
    end

    // Storage is left unreset; an empty channel masks it through count.
    always_ff @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (push[ch]) mem[ch][wr_ptr[ch]] <= {in_data, in_addr};
        end
    end

    assign out_valid_1 = (count[0] != '0);
    assign out_valid_2 = (count[1] != '0);
    assign out_data_1  = out_valid_1 ? mem[0][rd_ptr[0]][63:32] : '0;
    assign out_addr_1  = out_valid_1 ? mem[0][rd_ptr[0]][31:0]  : '0;
    assign out_data_2  = out_valid_2 ? mem[1][rd_ptr[1]][63:32] : '0;
    assign out_addr_2  = out_valid_2 ? mem[1][rd_ptr[1]][31:0]  : '0;
    assign count_1     = count[0];
    assign count_2     = count[1];
    assign bad_id      = bad_id_r;

endmodule
